pipe_hazard_ctrl: RTL and testbench

- Central stall/flush controller for the 5-stage pipeline.
- Drives the hold inputs of the PC register and of IF_ID (`is_hold`), plus flush/bubble controls for IF_ID, ID_EX and EX_MEM.
- Resolves load-use hazards, taken-branch squashes, multi-cycle MULT/DIV occupancy of EX, and instruction-memory wait states.
- Contains one FSM with a down-counter for MULT/DIV sequencing.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 21 ++
 rtl/load_use_detect.sv | 29 ++
 rtl/pipe_hazard_ctrl.sv | 156 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_hazard_ctrl_pkg
//  Brief    : Shared state encodings and MULT/DIV timing constants for the
//             pipeline hazard controller and the MDU datapath.
//  Revision : 1.0 - initial release
// ============================================================================
package pipe_hazard_ctrl_pkg;

    localparam int C_REG_ADDR_W  = 5;
    localparam int C_MULT_CYCLES = 4;
    localparam int C_DIV_CYCLES  = 32;
    localparam int C_CNT_W       = 6;

    typedef enum logic [0:0] {
        S_RUN = 1'b0,
        S_MDU = 1'b1
    } state_t;

endpackage : pipe_hazard_ctrl_pkg
`default_nettype wire

// File: rtl/load_use_detect.sv
`default_nettype none
// ============================================================================
//  Module   : load_use_detect
//  Brief    : Combinational detection of a load in EX feeding the ID source.
//  Revision : 1.0 - initial release
// ============================================================================
module load_use_detect
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = C_REG_ADDR_W
) (
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    output logic                  lu
);

    logic w_rs_match;
    logic w_rt_match;

    // Register zero is hard-wired, so a load targeting it never creates a hazard.
    assign w_rs_match = (ex_rt == id_rs);
    assign w_rt_match = id_uses_rt & (ex_rt == id_rt);
    assign lu         = ex_mem_read & (ex_rt != '0) & (w_rs_match | w_rt_match);

endmodule : load_use_detect
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_hazard_ctrl
//  Brief    : Stall/flush controller for the 5-stage pipeline (load-use,
//             taken branch, MULT/DIV occupancy, I-mem wait states).
//             Optional stall counter enabled by PIPE_HAZARD_STATS_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W  = C_REG_ADDR_W,
    parameter int MULT_CYCLES = C_MULT_CYCLES,
    parameter int DIV_CYCLES  = C_DIV_CYCLES,
    parameter int CNT_W       = C_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic                  branch_taken_ex,
    input  logic                  mdu_start,
    input  logic                  mdu_is_div,
    input  logic                  imem_ready,
    output logic                  pc_hold,
    output logic                  if_id_hold,
    output logic                  if_id_flush,
    output logic                  id_ex_hold,
    output logic                  id_ex_bubble,
    output logic                  ex_mem_bubble,
    output logic                  mdu_done,
    output logic                  mdu_busy
`ifdef PIPE_HAZARD_STATS_EN
    ,
    output logic [31:0]           stall_cycles
`endif
);

    // The start cycle counts toward occupancy and the done cycle ends it.
    localparam logic [CNT_W-1:0] C_MULT_LOAD = CNT_W'(MULT_CYCLES - 2);
    localparam logic [CNT_W-1:0] C_DIV_LOAD  = CNT_W'(DIV_CYCLES - 2);

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_lu;

    logic w_pc_hold;
    logic w_if_id_hold;
    logic w_if_id_flush;
    logic w_id_ex_hold;
    logic w_id_ex_bubble;
    logic w_ex_mem_bubble;
    logic w_mdu_done;
    logic w_mdu_busy;

    load_use_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_load_use_detect (
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .ex_mem_read (ex_mem_read),
        .ex_rt       (ex_rt),
        .lu          (w_lu)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_next_state    = r_state;
        w_cnt_next      = r_cnt;
        w_pc_hold       = 1'b0;
        w_if_id_hold    = 1'b0;
        w_if_id_flush   = 1'b0;
        w_id_ex_hold    = 1'b0;
        w_id_ex_bubble  = 1'b0;
        w_ex_mem_bubble = 1'b0;
        w_mdu_done      = 1'b0;
        w_mdu_busy      = 1'b0;

        case (r_state)
            S_RUN: begin
                if (branch_taken_ex) begin
                    w_if_id_flush  = 1'b1;
                    w_id_ex_bubble = 1'b1;
                end else if (mdu_start) begin
                    w_next_state = S_MDU;
                    w_cnt_next   = mdu_is_div ? C_DIV_LOAD : C_MULT_LOAD;
                end else if (w_lu) begin
                    w_pc_hold      = 1'b1;
                    w_if_id_hold   = 1'b1;
                    w_id_ex_bubble = 1'b1;
                end else if (!imem_ready) begin
                    // Fetch stalls; the older instructions keep draining.
                    w_pc_hold     = 1'b1;
                    w_if_id_flush = 1'b1;
                end
            end
            S_MDU: begin
                w_mdu_busy = 1'b1;
                if (r_cnt == '0) begin
                    w_mdu_done   = 1'b1;
                    w_next_state = S_RUN;
                end else begin
                    w_pc_hold       = 1'b1;
                    w_if_id_hold    = 1'b1;
                    w_id_ex_hold    = 1'b1;
                    w_ex_mem_bubble = 1'b1;
                    w_cnt_next      = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_next_state = S_RUN;
            end
        endcase
    end

    // S_RUN outputs are Mealy, so mask them directly while reset is held.
    assign pc_hold       = rst & w_pc_hold;
    assign if_id_hold    = rst & w_if_id_hold;
    assign if_id_flush   = rst & w_if_id_flush;
    assign id_ex_hold    = rst & w_id_ex_hold;
    assign id_ex_bubble  = rst & w_id_ex_bubble;
    assign ex_mem_bubble = rst & w_ex_mem_bubble;
    assign mdu_done      = rst & w_mdu_done;
    assign mdu_busy      = rst & w_mdu_busy;

`ifdef PIPE_HAZARD_STATS_EN
    logic [31:0] r_stall_cycles;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cycles <= '0;
        end else if (pc_hold && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`endif

endmodule : pipe_hazard_ctrl
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_hazard_ctrl
//  Brief    : Directed self-checking bench for pipe_hazard_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rt;
    logic       ex_mem_read;
    logic [4:0] ex_rt;
    logic       branch_taken_ex;
    logic       mdu_start;
    logic       mdu_is_div;
    logic       imem_ready;
    logic       pc_hold;
    logic       if_id_hold;
    logic       if_id_flush;
    logic       id_ex_hold;
    logic       id_ex_bubble;
    logic       ex_mem_bubble;
    logic       mdu_done;
    logic       mdu_busy;
`ifdef PIPE_HAZARD_STATS_EN
    logic [31:0] stall_cycles;
`endif

    int total;
    int bad;

    // {pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_bubble, ex_mem_bubble, mdu_done, mdu_busy}
    logic [7:0] obs;
    assign obs = {pc_hold, if_id_hold, if_id_flush, id_ex_hold,
                  id_ex_bubble, ex_mem_bubble, mdu_done, mdu_busy};

    localparam logic [7:0] E_IDLE   = 8'b0000_0000;
    localparam logic [7:0] E_LU     = 8'b1100_1000;
    localparam logic [7:0] E_BRANCH = 8'b0010_1000;
    localparam logic [7:0] E_IMEM   = 8'b1010_0000;
    localparam logic [7:0] E_MDU    = 8'b1101_0101;
    localparam logic [7:0] E_DONE   = 8'b0000_0011;

    pipe_hazard_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rt      (id_uses_rt),
        .ex_mem_read     (ex_mem_read),
        .ex_rt           (ex_rt),
        .branch_taken_ex (branch_taken_ex),
        .mdu_start       (mdu_start),
        .mdu_is_div      (mdu_is_div),
        .imem_ready      (imem_ready),
        .pc_hold         (pc_hold),
        .if_id_hold      (if_id_hold),
        .if_id_flush     (if_id_flush),
        .id_ex_hold      (id_ex_hold),
        .id_ex_bubble    (id_ex_bubble),
        .ex_mem_bubble   (ex_mem_bubble),
        .mdu_done        (mdu_done),
        .mdu_busy        (mdu_busy)
`ifdef PIPE_HAZARD_STATS_EN
        ,
        .stall_cycles    (stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge; inputs change here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs           = 5'd0;
        id_rt           = 5'd0;
        id_uses_rt      = 1'b0;
        ex_mem_read     = 1'b0;
        ex_rt           = 5'd0;
        branch_taken_ex = 1'b0;
        mdu_start       = 1'b0;
        mdu_is_div      = 1'b0;
        imem_ready      = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        branch_taken_ex = 1'b1;
        imem_ready      = 1'b0;
        ex_mem_read     = 1'b1;
        ex_rt           = 5'd5;
        id_rs           = 5'd5;
        mdu_start       = 1'b1;
        #1;
        total++;
        if (obs !== E_IDLE) begin
            $display("FAIL reset_outputs: got %b expected %b", obs, E_IDLE);
            bad++;
        end
        tick();
        tick();
        total++;
        if (obs !== E_IDLE) begin
            $display("FAIL reset_outputs_held: got %b expected %b", obs, E_IDLE);
            bad++;
        end
        idle_inputs();
        rst = 1'b1;
        #1;
        total++;
        if (obs !== E_IDLE) begin
            $display("FAIL reset_release_idle: got %b expected %b", obs, E_IDLE);
            bad++;
        end
        tick();
        total++;
        if (obs !== E_IDLE) begin
            $display("FAIL reset_state_run: got %b expected %b", obs, E_IDLE);
            bad++;
        end
    endtask

    task automatic test_load_use();
        idle_inputs();
        ex_mem_read = 1'b1;
        ex_rt       = 5'd5;
        id_rs       = 5'd5;
        #1;
        total++;
        if (obs !== E_LU) begin
            $display("FAIL lu_rs: got %b expected %b", obs, E_LU);
            bad++;
        end
        tick();
        idle_inputs();
        #1;
        total++;
        if (obs !== E_IDLE) begin
            $display("FAIL lu_release: got %b expected %b", obs, E_IDLE);
            bad++;
        end
        ex_mem_read = 1'b1;
        ex_rt       = 5'd0;
        id_rs       = 5'd0;
        #1;
        total++;
        if (obs !== E_IDLE) begin
            $display("FAIL lu_r0: got %b expected %b", obs, E_IDLE);
            bad++;
        end
        tick();
        ex_mem_read = 1'b1;
        ex_rt       = 5'd7;
        id_rt       = 5'd7;
        id_rs       = 5'd3;
        id_uses_rt  = 1'b1;
        #1;
        total++;
        if (obs !== E_LU) begin
            $display("FAIL lu_rt: got %b expected %b", obs, E_LU);
            bad++;
        end
        id_uses_rt = 1'b0;
        #1;
        total++;
        if (obs !== E_IDLE) begin
            $display("FAIL lu_rt_unused: got %b expected %b", obs, E_IDLE);
            bad++;
        end
        ex_mem_read = 1'b0;
        id_rs       = 5'd7;
        #1;
        total++;
        if (obs !== E_IDLE) begin
            $display("FAIL lu_not_load: got %b expected %b", obs, E_IDLE);
            bad++;
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_branch_vs_lu();
        idle_inputs();
        branch_taken_ex = 1'b1;
        ex_mem_read     = 1'b1;
        ex_rt           = 5'd9;
        id_rs           = 5'd9;
        imem_ready      = 1'b0;
        mdu_start       = 1'b1;
        #1;
        total++;
        if (obs !== E_BRANCH) begin
            $display("FAIL branch_priority: got %b expected %b", obs, E_BRANCH);
            bad++;
        end
        tick();
        idle_inputs();
        #1;
        total++;
        if (obs !== E_IDLE) begin
            $display("FAIL branch_no_mdu: got %b expected %b", obs, E_IDLE);
            bad++;
        end
        tick();
    endtask

    task automatic test_imem_wait();
        idle_inputs();
        imem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++;
            if (obs !== E_IMEM) begin
                $display("FAIL imem_wait_%0d: got %b expected %b", k, obs, E_IMEM);
                bad++;
            end
            tick();
        end
        imem_ready = 1'b1;
        #1;
        total++;
        if (obs !== E_IDLE) begin
            $display("FAIL imem_ready: got %b expected %b", obs, E_IDLE);
            bad++;
        end
        tick();
    endtask

    // Start a MULT/DIV at the current cycle and check every following cycle.
    task automatic run_mdu(input logic is_div, input int n_cycles, input string tag);
        logic [7:0] exp;
        idle_inputs();
        mdu_start  = 1'b1;
        mdu_is_div = is_div;
        #1;
        total++;
        if (obs !== E_IDLE) begin
            $display("FAIL %s_start: got %b expected %b", tag, obs, E_IDLE);
            bad++;
        end
        tick();
        idle_inputs();
        for (int k = 1; k < n_cycles; k++) begin
            // Ignored inputs thrown at the busy FSM.
            branch_taken_ex = (k == 1);
            imem_ready      = (k != 1);
            mdu_start       = (k == 1);
            exp = (k == n_cycles - 1) ? E_DONE : E_MDU;
            #1;
            total++;
            if (obs !== exp) begin
                $display("FAIL %s_cycle_%0d: got %b expected %b", tag, k, obs, exp);
                bad++;
            end
            tick();
            idle_inputs();
        end
        #1;
        total++;
        if (obs !== E_IDLE) begin
            $display("FAIL %s_back_to_run: got %b expected %b", tag, obs, E_IDLE);
            bad++;
        end
    endtask

    task automatic test_div();
        run_mdu(1'b1, 32, "div");
        tick();
    endtask

    task automatic test_mult();
        run_mdu(1'b0, 4, "mult");
        tick();
    endtask

    task automatic test_back_to_back();
        run_mdu(1'b0, 4, "b2b_first");
        run_mdu(1'b0, 4, "b2b_second");
        tick();
    endtask

    task automatic test_reset_mid_div();
        idle_inputs();
        mdu_start  = 1'b1;
        mdu_is_div = 1'b1;
        tick();
        idle_inputs();
        for (int k = 1; k < 10; k++) tick();
        #1;
        total++;
        if (obs !== E_MDU) begin
            $display("FAIL rstdiv_busy: got %b expected %b", obs, E_MDU);
            bad++;
        end
        rst = 1'b0;
        #1;
        total++;
        if (obs !== E_IDLE) begin
            $display("FAIL rstdiv_immediate: got %b expected %b", obs, E_IDLE);
            bad++;
        end
        tick();
        rst = 1'b1;
        begin
            int seen;
            seen = 0;
            for (int k = 0; k < 30; k++) begin
                #1;
                if (obs !== E_IDLE) seen++;
                tick();
            end
            total++;
            if (seen != 0) begin
                $display("FAIL rstdiv_quiet: got %0d non-idle cycles expected 0", seen);
                bad++;
            end
        end
        run_mdu(1'b0, 4, "rstdiv_restart");
        tick();
    endtask

`ifdef PIPE_HAZARD_STATS_EN
    task automatic test_stats();
        rst = 1'b0;
        idle_inputs();
        tick();
        rst = 1'b1;
        #1;
        total++;
        if (stall_cycles !== 32'd0) begin
            $display("FAIL stats_reset: got %0d expected 0", stall_cycles);
            bad++;
        end
        ex_mem_read = 1'b1;
        ex_rt       = 5'd4;
        id_rs       = 5'd4;
        tick();
        idle_inputs();
        run_mdu(1'b0, 4, "stats_mult");
        // One load-use stall plus MULT_CYCLES-2 frozen cycles.
        total++;
        if (stall_cycles !== 32'd3) begin
            $display("FAIL stats_count: got %0d expected 3", stall_cycles);
            bad++;
        end
        tick();
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        idle_inputs();
        tick();
        test_reset();
        test_load_use();
        test_branch_vs_lu();
        test_imem_wait();
        test_mult();
        test_div();
        test_back_to_back();
        test_reset_mid_div();
`ifdef PIPE_HAZARD_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_pipe_hazard_ctrl
`default_nettype wire
